seq_detector_param: RTL and testbench

Parametrised Moore sequence detector, the successor of the fixed 1010 detector. It compares a serial bit stream against a compile-time pattern of configurable length. Overlap or non-overlap matching is selected at run time, and a saturating match counter is provided. It sits in the serial front end, between the bit sampler and the control/status logic.

---
 rtl/seq_detector_param.sv | 74 +++++++
 tb/tb_seq_detector_param.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Parametrised Moore sequence detector for the serial front end.
// It matches a compile-time pattern, supports overlap or non-overlap matching, and keeps a saturating match count.
module seq_detector_param #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1010,
  parameter int                   CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             en,
  input  logic             overlap,
  input  logic             clr,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
);

  generate
    if (PATTERN_W < 2 || PATTERN_W > 16) begin : g_bad_pattern_w
      $fatal(1, "seq_detector_param: PATTERN_W must be in 2..16");
    end
    if (CNT_W < 1 || CNT_W > 16) begin : g_bad_cnt_w
      $fatal(1, "seq_detector_param: CNT_W must be in 1..16");
    end
  endgenerate

  localparam int                FILL_W    = $clog2(PATTERN_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [PATTERN_W-1:0] hist;
  logic [PATTERN_W-1:0] hist_n;
  logic [FILL_W-1:0]    fill;
  logic [FILL_W-1:0]    fill_n;
  logic                 hit;

  function automatic logic [FILL_W-1:0] fill_sat_inc(input logic [FILL_W-1:0] f);
    return (f == FILL_FULL) ? f : f + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  // The fill gate keeps stale zeros in hist from matching an all-zero pattern.
  always_comb begin
    hist_n = {hist[PATTERN_W-2:0], x};
    fill_n = fill_sat_inc(fill);
    hit    = (fill_n == FILL_FULL) && (hist_n == PATTERN);
  end

  // Registered state and outputs: z depends only on flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist      <= '0;
      fill      <= '0;
      z         <= 1'b0;
      match_cnt <= '0;
    end else if (clr) begin
      hist      <= '0;
      fill      <= '0;
      z         <= 1'b0;
      match_cnt <= '0;
    end else if (!en) begin
      z <= 1'b0;
    end else begin
      hist <= hist_n;
      z    <= hit;
      fill <= (hit && !overlap) ? '0 : fill_n;
      if (hit) match_cnt <= cnt_sat_inc(match_cnt);
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Testbench for seq_detector_param. Three configurations share one stimulus stream.
// Each configuration is compared against a scoreboard fed by an arithmetic reference model.
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic x = 1'b0, en = 1'b0, overlap = 1'b0, clr = 1'b0;
  logic z0, z1, z2;
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  logic [7:0] cnt2;

  always #5 clk = ~clk;

  seq_detector_param u0 (
    .clk(clk), .rst_n(rst_n), .x(x), .en(en), .overlap(overlap), .clr(clr),
    .z(z0), .match_cnt(cnt0));

  seq_detector_param #(.PATTERN_W(2), .PATTERN(2'b11), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .x(x), .en(en), .overlap(overlap), .clr(clr),
    .z(z1), .match_cnt(cnt1));

  seq_detector_param #(.PATTERN_W(4), .PATTERN(4'b0000), .CNT_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .x(x), .en(en), .overlap(overlap), .clr(clr),
    .z(z2), .match_cnt(cnt2));

  int nchk = 0;
  int nerr = 0;

  // Reference model: the value of the bits seen since the window opened, and the number of those bits.
  int pw[3]   = '{4, 2, 4};
  int pat[3]  = '{10, 3, 0};
  int cmax[3] = '{255, 3, 255};
  int m_val[3], m_n[3], m_cnt[3], m_z[3];

  int eq0[$], eq1[$], eq2[$];

  task automatic check(string name, logic [31:0] act, int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_val[k] = 0; m_n[k] = 0; m_cnt[k] = 0; m_z[k] = 0;
    end
  endfunction

  function automatic void model_step(int k, bit xi, bit ei, bit oi, bit ci);
    int mask;
    mask = (1 << pw[k]) - 1;
    m_z[k] = 0;
    if (ci) begin
      m_val[k] = 0; m_n[k] = 0; m_cnt[k] = 0;
    end else if (ei) begin
      m_val[k] = ((m_val[k] << 1) | int'(xi)) & 'hFFFF;
      m_n[k]++;
      if (m_n[k] >= pw[k] && (m_val[k] & mask) == pat[k]) begin
        m_z[k] = 1;
        if (m_cnt[k] < cmax[k]) m_cnt[k]++;
        if (!oi) m_n[k] = 0;
      end
    end
  endfunction

  task automatic cycle(bit xi, bit ei, bit oi, bit ci);
    @(negedge clk);
    x = xi; en = ei; overlap = oi; clr = ci;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k, xi, ei, oi, ci);
    eq0.push_back(m_z[0] * 1024 + m_cnt[0]);
    eq1.push_back(m_z[1] * 1024 + m_cnt[1]);
    eq2.push_back(m_z[2] * 1024 + m_cnt[2]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b0; clr = 1'b0;
    model_reset();
    #1;
    check("rst.z0", z0, m_z[0]);
    check("rst.cnt0", cnt0, m_cnt[0]);
    check("rst.z1", z1, m_z[1]);
    check("rst.cnt1", cnt1, m_cnt[1]);
    check("rst.z2", z2, m_z[2]);
    check("rst.cnt2", cnt2, m_cnt[2]);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic stream(int bits, int n, bit ov);
    for (int i = n - 1; i >= 0; i--) cycle(bits[i], 1'b1, ov, 1'b0);
  endtask

  // Monitor: compare every presented output cycle against the scoreboard.
  always @(posedge clk) begin
    int e;
    #2;
    if (eq0.size() > 0) begin
      e = eq0.pop_front();
      check("u0.z", z0, e / 1024);
      check("u0.cnt", cnt0, e % 1024);
    end
    if (eq1.size() > 0) begin
      e = eq1.pop_front();
      check("u1.z", z1, e / 1024);
      check("u1.cnt", cnt1, e % 1024);
    end
    if (eq2.size() > 0) begin
      e = eq2.pop_front();
      check("u2.z", z2, e / 1024);
      check("u2.cnt", cnt2, e % 1024);
    end
  end

  initial begin
    int zexp[6];
    int cexp[6];
    bit ov;
    int r;
    zexp = '{0, 1, 1, 1, 1, 1};
    cexp = '{0, 1, 2, 3, 3, 3};

    model_reset();
    do_reset();

    stream('b10101010, 8, 1'b0);
    #3 check("nonoverlap.cnt", cnt0, 2);

    do_reset();
    stream('b10101010, 8, 1'b1);
    #3 check("overlap.cnt", cnt0, 3);

    do_reset();
    stream('b1011010, 7, 1'b1);
    #3 check("partial.cnt", cnt0, 1);

    do_reset();
    stream('b10, 2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(i[0], 1'b0, 1'b0, 1'b0);
      #3 check("engap.z", z0, 0);
    end
    stream('b10, 2, 1'b0);
    #3 check("engap.zfinal", z0, 1);
    check("engap.cnt", cnt0, 1);

    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      #3;
      check("sat.z", z1, zexp[i]);
      check("sat.cnt", cnt1, cexp[i]);
    end

    do_reset();
    stream('b1010, 4, 1'b0);
    #3 check("prerst.z", z0, 1);
    do_reset();
    stream('b101, 3, 1'b0);
    do_reset();
    stream('b0, 1, 1'b0);
    #3 check("postrst.z", z0, 0);

    do_reset();
    stream('b1010101, 7, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    #3 check("clr.z", z0, 0);
    check("clr.cnt", cnt0, 0);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      #3 check("zeros.z", z2, (i == 3) ? 1 : 0);
    end

    ov = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 199);
      if (r == 0) do_reset();
      else begin
        if ($urandom_range(0, 15) == 0) ov = ~ov;
        cycle(1'($urandom), r > 40, ov, r > 196);
      end
    end

    repeat (2) @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
